// File: rtl/emisor_pulsos_temporizado_pkg.sv
// Shared parking-controller definitions: output FSM states and timing constants.
package pkg_estacionamiento;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ALTO   = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  localparam int unsigned CLK_HZ     = 12_000_000;
  localparam logic [19:0] TICKS_20MS = 20'd240_000;

endpackage

// File: rtl/emisor_pulsos_temporizado_temporizador.sv
// Free-running tick counter with synchronous clear and a runtime terminal-count compare.
module temporizador_ticks #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limite,
  output logic             fin
);

  logic [CNT_W-1:0] tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
    end else if (clear) begin
      tick_reg <= '0;
    end else if (enable) begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  assign fin = (tick_reg == limite);

endmodule

// File: rtl/emisor_pulsos_temporizado.sv
// Emits one fixed-width output pulse per request, with a minimum low gap and a
// saturating queue for requests that arrive while a pulse or gap is running.
module emisor_pulsos_temporizado
  import pkg_estacionamiento::*;
#(
  parameter int unsigned       CNT_W       = 20,
  parameter int unsigned       PEND_W      = 4,
  parameter logic [CNT_W-1:0]  PULSE_TICKS = TICKS_20MS,
  parameter logic [CNT_W-1:0]  GAP_TICKS   = TICKS_20MS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disparo,
  output logic              salida,
  output logic              ocupado,
  output logic [PEND_W-1:0] pendientes,
  output logic              desborde
);

  localparam logic [CNT_W-1:0]  PULSE_LIM = PULSE_TICKS - 1'b1;
  localparam logic [CNT_W-1:0]  GAP_LIM   = GAP_TICKS - 1'b1;
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  estado_t           state_reg;
  logic              salida_reg;
  logic              ocupado_reg;
  logic              desborde_reg;
  logic [PEND_W-1:0] pend_reg;
  logic [PEND_W-1:0] pend_next;

  logic [CNT_W-1:0]  limite;
  logic              fin;
  logic              hay_pend;
  logic              launch;
  logic              acc;
  logic              cons;
  logic              drop;

  // One timer serves both phases; it restarts on every phase change.
  assign limite = (state_reg == ALTO) ? PULSE_LIM : GAP_LIM;

  temporizador_ticks #(
    .CNT_W (CNT_W)
  ) u_temporizador (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_reg == REPOSO) || fin),
    .enable (state_reg != REPOSO),
    .limite (limite),
    .fin    (fin)
  );

  assign hay_pend = (pend_reg != '0);
  assign launch   = (state_reg == PAUSA) && fin && (hay_pend || disparo);
  // A request landing on a launch with an empty queue goes straight out.
  assign acc      = disparo && (state_reg != REPOSO) && !(launch && !hay_pend);
  assign cons     = launch && hay_pend;
  assign drop     = acc && !cons && (pend_reg == PEND_MAX);

  always_comb begin
    pend_next = pend_reg;
    if (acc && !cons && !drop) begin
      pend_next = pend_reg + 1'b1;
    end else if (cons && !acc) begin
      pend_next = pend_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= REPOSO;
      salida_reg   <= 1'b0;
      ocupado_reg  <= 1'b0;
      desborde_reg <= 1'b0;
      pend_reg     <= '0;
    end else begin
      desborde_reg <= drop;
      pend_reg     <= pend_next;
      case (state_reg)
        REPOSO: begin
          if (disparo) begin
            state_reg   <= ALTO;
            salida_reg  <= 1'b1;
            ocupado_reg <= 1'b1;
          end
        end
        ALTO: begin
          if (fin) begin
            state_reg  <= PAUSA;
            salida_reg <= 1'b0;
          end
        end
        PAUSA: begin
          if (launch) begin
            state_reg  <= ALTO;
            salida_reg <= 1'b1;
          end else if (fin) begin
            state_reg   <= REPOSO;
            ocupado_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= REPOSO;
          salida_reg  <= 1'b0;
          ocupado_reg <= 1'b0;
        end
      endcase
    end
  end

  assign salida     = salida_reg;
  assign ocupado    = ocupado_reg;
  assign pendientes = pend_reg;
  assign desborde   = desborde_reg;

endmodule
